// File: rtl/cpu_defs.sv
// cpu_defs: shared XLEN default, RISC-V opcodes and prefetch FSM state encodings
package cpu_defs;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: instruction queue storage with wrapping head/tail pointers, flush and occupancy count
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d = flush ? '0 : head_q + AW'(pop);
    tail_d = flush ? '0 : tail_q + AW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end
  assign head_data = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: FETCH/FULL fetch FSM, fetch-PC and redirect logic over prefetch_fifo; PREFETCH_BTFN_EN enables BTFN prediction
module prefetch_unit
  import cpu_defs::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            rom_address,
  output logic                       rom_req,
  input  logic                       rom_ready,
  input  logic [31:0]                rom_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_target,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr,
  output logic [XLEN-1:0]            pc,
  output logic                       pred_taken,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
`ifdef PREFETCH_BTFN_EN
  localparam int WIDTH = 33 + XLEN;
`else
  localparam int WIDTH = 32 + XLEN;
`endif
  state_e state_q, state_d;
  logic run_q;
  logic [XLEN-1:0] pc_q, pc_d, step;
  logic push, pop;
  logic [CW-1:0] cnt_d;
  logic [WIDTH-1:0] push_data, head;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      run_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
      pc_q <= pc_d;
    end
  end
  always_comb begin
    state_d = (!redirect && cnt_d == CW'(DEPTH)) ? FULL : FETCH;
  end
  always_comb begin
    rom_req = run_q && state_q == FETCH;
    rom_address = pc_q;
    instr_valid = count != '0;
    instr = instr_valid ? head[XLEN+31:XLEN] : '0;
    pc = instr_valid ? head[XLEN-1:0] : '0;
`ifdef PREFETCH_BTFN_EN
    pred_taken = instr_valid && head[WIDTH-1];
`else
    pred_taken = 1'b0;
`endif
  end
`ifdef PREFETCH_BTFN_EN
  logic signed [31:0] imm;
  logic taken;
  always_comb begin
    taken = rom_data[6:0] == OPC_JAL || (rom_data[6:0] == OPC_BRANCH && rom_data[31]);
    imm = rom_data[6:0] == OPC_JAL
      ? {{11{rom_data[31]}}, rom_data[31], rom_data[19:12], rom_data[20], rom_data[30:21], 1'b0}
      : {{19{rom_data[31]}}, rom_data[31], rom_data[7], rom_data[30:25], rom_data[11:8], 1'b0};
    step = taken ? XLEN'(imm) : XLEN'(4);
    push_data = {taken, rom_data, pc_q};
  end
`else
  always_comb begin
    step = XLEN'(4);
    push_data = {rom_data, pc_q};
  end
`endif
  always_comb begin
    push = rom_req && rom_ready && !redirect;
    pop = instr_valid && instr_ready && !redirect;
    cnt_d = redirect ? '0 : count + CW'(push) - CW'(pop);
    pc_d = redirect ? {redirect_target[XLEN-1:2], 2'b00} : push ? pc_q + step : pc_q;
  end
  prefetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .push(push),
    .pop(pop),
    .push_data(push_data),
    .head_data(head),
    .count(count)
  );
endmodule
